// File: rtl/proc_flags_if.sv
// Bus between the proc_flags core and its synchronous memory / peripherals,
// plus the Run permit and the Done/Flags status lines.
interface proc_flags_if #(parameter int WIDTH = 16);
    logic             Run;
    logic [WIDTH-1:0] DIN;
    logic [WIDTH-1:0] ADDR;
    logic [WIDTH-1:0] DOUT;
    logic             W;
    logic             Done;
    logic [2:0]       Flags;

    modport master (input Run, input DIN,
                    output ADDR, output DOUT, output W, output Done, output Flags);
    modport slave  (output Run, output DIN,
                    input ADDR, input DOUT, input W, input Done, input Flags);
endinterface

// File: rtl/proc_flags.sv
// Multi-cycle WIDTH-bit fetch/execute core with a {N,C,Z} flag register
// and a conditional PC-relative branch; r7 doubles as the program counter.
module proc_flags #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic         Clock,
    input  logic         Reset,
    proc_flags_if.master bus
);
    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LD  = 3'b100;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_BR  = 3'b111;

    localparam logic [1:0] SRC_B   = 2'd0;
    localparam logic [1:0] SRC_MVT = 2'd1;
    localparam logic [1:0] SRC_G   = 2'd2;
    localparam logic [1:0] SRC_DIN = 2'd3;

    state_t state, state_next;

    logic [WIDTH-1:0] regs [8];
    logic [WIDTH-1:0] ir, a_reg, g_reg, addr_reg, dout_reg;
    logic             w_reg;
    logic [2:0]       flags;

    logic [2:0]              op, rx, ry, rx_dst;
    logic                    m;
    logic signed [WIDTH-1:0] imm;
    logic [WIDTH-1:0]        opnd_b, mvt_val, rx_data, g_next;
    logic [WIDTH:0]          alu_out;
    logic                    take;

    logic       ir_we, addr_pc, addr_ry, pc_inc, a_we, a_from_pc;
    logic       g_we, g_branch, flags_we, st_we, rx_we, done;
    logic [1:0] rx_src;

    // Returns {carry, result}; subtraction is A + ~B + 1 so carry means A >= B.
    function automatic logic [WIDTH:0] alu_eval(input logic [2:0] code,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH:0] r;
        case (code)
            OP_ADD:  r = {1'b0, x} + {1'b0, y};
            OP_SUB:  r = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
            default: r = {1'b0, x & y};
        endcase
        return r;
    endfunction

    function automatic logic cond_met(input logic [2:0] cc, input logic [2:0] nzc);
        case (cc)
            3'b000:  return 1'b1;
            3'b001:  return nzc[0];
            3'b010:  return !nzc[0];
            3'b011:  return !nzc[1];
            3'b100:  return nzc[1];
            3'b101:  return !nzc[2];
            3'b110:  return nzc[2];
            default: return 1'b0;
        endcase
    endfunction

    assign op      = ir[WIDTH-1 -: 3];
    assign m       = ir[WIDTH-4];
    assign rx      = ir[WIDTH-5 -: 3];
    assign ry      = ir[2:0];
    assign imm     = {{7{ir[WIDTH-8]}}, ir[WIDTH-8:0]};
    assign mvt_val = {ir[7:0], {(WIDTH-8){1'b0}}};
    assign opnd_b  = m ? imm : regs[ry];
    assign alu_out = alu_eval(op, a_reg, opnd_b);
    assign take    = cond_met(rx, flags);
    assign rx_dst  = (op == OP_BR) ? 3'd7 : rx;
    assign g_next  = g_branch ? a_reg + imm : alu_out[WIDTH-1:0];

    always_comb begin
        rx_data = opnd_b;
        case (rx_src)
            SRC_MVT: rx_data = mvt_val;
            SRC_G:   rx_data = g_reg;
            SRC_DIN: rx_data = bus.DIN;
            default: rx_data = opnd_b;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) state <= T0;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            T0: if (bus.Run) state_next = T1;
            T1: state_next = T2;
            T2: state_next = T3;
            T3: begin
                case (op)
                    OP_MV, OP_MVT: state_next = T0;
                    OP_BR:         state_next = take ? T4 : T0;
                    default:       state_next = T4;
                endcase
            end
            T4: state_next = (op == OP_ST) ? T0 : T5;
            T5: state_next = T0;
            default: state_next = T0;
        endcase
    end

    always_comb begin
        ir_we = 1'b0; addr_pc = 1'b0; addr_ry = 1'b0; pc_inc = 1'b0;
        a_we = 1'b0; a_from_pc = 1'b0; g_we = 1'b0; g_branch = 1'b0;
        flags_we = 1'b0; st_we = 1'b0; rx_we = 1'b0; done = 1'b0;
        rx_src = SRC_B;
        case (state)
            T0: begin
                addr_pc = 1'b1;
                pc_inc  = bus.Run;
            end
            T2: ir_we = 1'b1;
            T3: begin
                case (op)
                    OP_MV:  begin rx_we = 1'b1; rx_src = SRC_B;   done = 1'b1; end
                    OP_MVT: begin rx_we = 1'b1; rx_src = SRC_MVT; done = 1'b1; end
                    OP_ADD, OP_SUB, OP_AND: a_we = 1'b1;
                    OP_LD, OP_ST:           addr_ry = 1'b1;
                    default: begin
                        if (take) begin a_we = 1'b1; a_from_pc = 1'b1; end
                        else      done = 1'b1;
                    end
                endcase
            end
            T4: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND: begin g_we = 1'b1; flags_we = 1'b1; end
                    OP_ST:                  begin st_we = 1'b1; done = 1'b1; end
                    OP_BR:                  begin g_we = 1'b1; g_branch = 1'b1; end
                    default: ;
                endcase
            end
            T5: begin
                done = 1'b1;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_BR: begin rx_we = 1'b1; rx_src = SRC_G; end
                    OP_LD:                         begin rx_we = 1'b1; rx_src = SRC_DIN; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // A register write to r7 is issued after the increment so it wins.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 7; i++) regs[i] <= '0;
            regs[7]  <= PC_RESET;
            ir       <= '0;
            a_reg    <= '0;
            g_reg    <= '0;
            addr_reg <= '0;
            dout_reg <= '0;
            w_reg    <= 1'b0;
            flags    <= 3'b000;
        end else begin
            w_reg <= st_we;
            if (ir_we)    ir       <= bus.DIN;
            if (addr_pc)  addr_reg <= regs[7];
            if (addr_ry)  addr_reg <= regs[ry];
            if (a_we)     a_reg    <= a_from_pc ? regs[7] : regs[rx];
            if (g_we)     g_reg    <= g_next;
            if (flags_we) flags    <= {alu_out[WIDTH-1], alu_out[WIDTH],
                                       alu_out[WIDTH-1:0] == '0};
            if (st_we)    dout_reg <= regs[rx];
            if (pc_inc)   regs[7]  <= regs[7] + WIDTH'(1);
            if (rx_we)    regs[rx_dst] <= rx_data;
        end
    end

    assign bus.ADDR  = addr_reg;
    assign bus.DOUT  = dout_reg;
    assign bus.W     = w_reg;
    assign bus.Flags = flags;
    assign bus.Done  = done;
endmodule

// File: tb/tb_proc_flags.sv
// Bench for proc_flags: random programs run against an instruction-level model,
// plus reset/Run gating, mid-instruction abort and a 32-bit build.
module tb_proc_flags;
    typedef struct {
        int          lat;
        logic [15:0] pc;
        logic [2:0]  fl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic load_req;
    logic mon_en;
    int   checks = 0;
    int   errors = 0;
    int   cnt = 0;

    always #5 clk = ~clk;

    proc_flags_if #(.WIDTH(16)) bus ();
    proc_flags_if #(.WIDTH(32)) bus32 ();

    proc_flags #(.WIDTH(16), .PC_RESET(16'h0000)) dut (
        .Clock(clk), .Reset(rst), .bus(bus));
    proc_flags #(.WIDTH(32), .PC_RESET(32'h0000_0010)) dut32 (
        .Clock(clk), .Reset(rst), .bus(bus32));

    logic [15:0] mem     [65536];
    logic [15:0] ref_mem [65536];
    logic [31:0] mem32   [64];
    logic [31:0] rom32   [64];

    logic [15:0] r [8];
    logic [2:0]  mflags;
    exp_t        exp_q[$];
    logic [31:0] store_q[$];
    logic [63:0] q32[$];

    // Synchronous memories: one-cycle read latency, write when W is high.
    always @(posedge clk) begin
        bus.DIN   <= mem[bus.ADDR];
        bus32.DIN <= mem32[bus32.ADDR[5:0]];
        if (load_req) begin
            for (int a = 0; a < 65536; a++) mem[a] = ref_mem[a];
            for (int a = 0; a < 64; a++) mem32[a] = rom32[a];
        end else begin
            if (bus.W)   mem[bus.ADDR] = bus.DOUT;
            if (bus32.W) mem32[bus32.ADDR[5:0]] = bus32.DOUT;
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) r[i] = 16'h0000;
        mflags = 3'b000;
    endtask

    // Executes one instruction at ISA level and records what the core must show.
    task automatic model_step();
        logic [15:0] pc, ir, bval, res;
        logic [2:0]  op, rx, ry;
        logic [7:0]  tbl;
        logic        z, cf, n, c;
        int          d, av, bv, sum, lat;
        pc = r[7];
        ir = ref_mem[pc];
        r[7] = pc + 16'd1;
        op = ir[15:13];
        rx = ir[11:9];
        ry = ir[2:0];
        d = int'(ir[8:0]);
        if (d >= 256) d = d - 512;
        bval = ir[12] ? 16'(d) : r[ry];
        av = int'(r[rx]);
        bv = int'(bval);
        lat = 6;
        case (op)
            3'd0: begin r[rx] = bval; lat = 4; end
            3'd1: begin r[rx] = 16'(int'(ir[7:0]) * 256); lat = 4; end
            3'd2, 3'd3, 3'd6: begin
                if (op == 3'd2)      begin sum = av + bv; c = (sum > 65535); end
                else if (op == 3'd3) begin sum = av - bv; c = (av >= bv); end
                else                 begin sum = av & bv; c = 1'b0; end
                res = 16'(sum);
                mflags = {res[15], c, res == 16'd0};
                r[rx] = res;
            end
            3'd4: r[rx] = ref_mem[r[ry]];
            3'd5: begin
                store_q.push_back({r[ry], r[rx]});
                ref_mem[r[ry]] = r[rx];
                lat = 5;
            end
            default: begin
                z = mflags[0]; cf = mflags[1]; n = mflags[2];
                tbl = {1'b0, n, !n, cf, !cf, !z, z, 1'b1};
                if (tbl[rx]) r[7] = 16'(int'(r[7]) + d);
                else         lat = 4;
            end
        endcase
        exp_q.push_back('{lat, pc, mflags});
    endtask

    task automatic load_mem();
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic run_random(input int n);
        int guard;
        rst = 1'b1;
        mon_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 65536; a++) ref_mem[a] = 16'($urandom);
        load_mem();
        model_reset();
        for (int k = 0; k < n; k++) model_step();
        bus.Run = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || store_q.size() != 0) && guard < n * 8 + 100) begin
            @(posedge clk);
            guard++;
        end
        chk("random_drain", 32'(exp_q.size() + store_q.size()), 32'd0);
        #1 rst = 1'b1;
        mon_en = 1'b0;
        exp_q.delete();
        store_q.delete();
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] s;
        if (rst || !mon_en) begin
            cnt = 0;
        end else begin
            cnt++;
            if (cnt == 2 && exp_q.size() > 0)
                chk("fetch_addr", 32'(bus.ADDR), 32'(exp_q[0].pc));
            if (bus.W) begin
                if (store_q.size() == 0) chk("unexpected_store", 32'(bus.W), 32'd0);
                else begin
                    s = store_q.pop_front();
                    chk("st_addr", 32'(bus.ADDR), 32'(s[31:16]));
                    chk("st_data", 32'(bus.DOUT), 32'(s[15:0]));
                end
            end
            if (bus.Done) begin
                if (exp_q.size() == 0) chk("unexpected_done", 32'(bus.Done), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("latency", 32'(cnt), 32'(e.lat));
                    chk("flags", 32'(bus.Flags), 32'(e.fl));
                end
                cnt = 0;
            end
        end
    end

    always @(negedge clk) begin : monitor32
        logic [63:0] e32;
        if (!rst && bus32.W) begin
            if (q32.size() == 0) chk("unexpected_store32", 32'(bus32.W), 32'd0);
            else begin
                e32 = q32.pop_front();
                chk("st32_addr", bus32.ADDR, e32[63:32]);
                chk("st32_data", bus32.DOUT, e32[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; load_req = 1'b0; mon_en = 1'b0;
        bus.Run = 1'b0; bus32.Run = 1'b0;
        for (int a = 0; a < 64; a++) rom32[a] = 32'h0;
        rom32[16] = 32'h2600_00A5;  // mvt r3,#0xA5
        rom32[17] = 32'h19FF_FFFF;  // mv  r4,#-1
        rom32[18] = 32'hA600_0005;  // st  r3,[r5]
        rom32[19] = 32'hA800_0005;  // st  r4,[r5]
        rom32[20] = 32'hE1FF_FFFF;  // b   self
        q32.push_back({32'h0, 32'hA500_0000});
        q32.push_back({32'h0, 32'hFFFF_FFFF});
        for (int a = 0; a < 65536; a++) ref_mem[a] = 16'h0;

        repeat (2) @(posedge clk);
        #1;
        load_mem();
        @(negedge clk);
        chk("reset_flags", 32'(bus.Flags), 32'd0);
        chk("reset_w", 32'(bus.W), 32'd0);
        chk("reset_done", 32'(bus.Done), 32'd0);
        chk("reset_addr", 32'(bus.ADDR), 32'd0);
        chk("reset_dout", 32'(bus.DOUT), 32'd0);
        chk("reset_addr32", bus32.ADDR, 32'd0);

        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            chk("run_low_addr", 32'(bus.ADDR), 32'd0);
            chk("run_low_done", 32'(bus.Done), 32'd0);
            chk("run_low_w", 32'(bus.W), 32'd0);
            chk("run_low_addr32", bus32.ADDR, 32'h10);
        end

        bus32.Run = 1'b1;
        run_random(400);
        bus32.Run = 1'b0;
        chk("st32_drain", 32'(q32.size()), 32'd0);

        // Abort an add in T4 by reset; the flag update must not happen.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rereset_flags", 32'(bus.Flags), 32'd0);
        chk("rereset_w", 32'(bus.W), 32'd0);
        for (int a = 0; a < 65536; a++) ref_mem[a] = 16'h0;
        ref_mem[0] = 16'h13FF;  // mv  r1,#-1
        ref_mem[1] = 16'h5301;  // add r1,#1
        @(posedge clk);
        #1;
        load_mem();
        model_reset();
        model_step();
        bus.Run = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_flags", 32'(bus.Flags), 32'd0);
        chk("abort_done", 32'(bus.Done), 32'd0);
        chk("abort_w", 32'(bus.W), 32'd0);
        chk("abort_addr", 32'(bus.ADDR), 32'd0);
        chk("abort_queue", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        exp_q.delete();

        run_random(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
